// File: rtl/axistream_pack_if.sv
// Narrow/wide AXI-Stream bundle for the pack converter.
// The slave modport is the converter's view: it consumes the narrow src_*
// stream and produces the wide dest_* stream. The master modport is the
// surrounding logic's view of the same signals.
interface axistream_pack_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4
);
  logic                           src_tvalid;
  logic                           src_tready;
  logic [DATA_WIDTH-1:0]          src_tdata;
  logic                           src_tlast;
  logic                           dest_tvalid;
  logic                           dest_tready;
  logic [NUM_PACK*DATA_WIDTH-1:0] dest_tdata;
  logic [NUM_PACK-1:0]            dest_tkeep;
  logic                           dest_tlast;

  modport slave (
    input  src_tvalid, src_tdata, src_tlast, dest_tready,
    output src_tready, dest_tvalid, dest_tdata, dest_tkeep, dest_tlast
  );

  modport master (
    output src_tvalid, src_tdata, src_tlast, dest_tready,
    input  src_tready, dest_tvalid, dest_tdata, dest_tkeep, dest_tlast
  );
endinterface

// File: rtl/axistream_pack.sv
// Narrow-to-wide AXI-Stream packer: gathers NUM_PACK narrow beats into one
// wide beat. A group closed early by src_tlast is emitted with the unwritten
// lanes zeroed and their dest_tkeep bits cleared. BIG_ENDIAN selects whether
// the first beat of a group lands in the top lane or in lane 0.
module axistream_pack #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  axistream_pack_if.slave axis
);

  localparam int                 CNT_W    = (NUM_PACK > 2) ? $clog2(NUM_PACK) : 1;
  localparam int                 WORD_W   = NUM_PACK * DATA_WIDTH;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(NUM_PACK - 1);

  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [WORD_W-1:0]   acc_data_q,  acc_data_d;
  logic [NUM_PACK-1:0] acc_keep_q,  acc_keep_d;
  logic                out_valid_q, out_valid_d;
  logic [WORD_W-1:0]   out_data_q,  out_data_d;
  logic [NUM_PACK-1:0] out_keep_q,  out_keep_d;
  logic                out_last_q,  out_last_d;

  logic                src_ready;
  logic                accept;
  logic                closing;
  logic [CNT_W-1:0]    lane;
  logic [WORD_W-1:0]   merged_data;
  logic [NUM_PACK-1:0] merged_keep;

  // The input may only move when the output register is free or draining now.
  assign src_ready = !out_valid_q || axis.dest_tready;
  assign accept    = axis.src_tvalid && src_ready;
  assign closing   = (cnt_q == LAST_CNT) || axis.src_tlast;

  // Lane for the current beat, then the accumulator with that beat merged in.
  always_comb begin
    lane        = BIG_ENDIAN ? (LAST_CNT - cnt_q) : cnt_q;
    merged_data = acc_data_q;
    merged_keep = acc_keep_q;
    for (int k = 0; k < NUM_PACK; k++) begin
      if (lane == CNT_W'(k)) begin
        merged_data[k*DATA_WIDTH +: DATA_WIDTH] = axis.src_tdata;
        merged_keep[k]                          = 1'b1;
      end
    end
  end

  // Next state: accumulate, close a group into the output register, or drain it.
  always_comb begin
    cnt_d       = cnt_q;
    acc_data_d  = acc_data_q;
    acc_keep_d  = acc_keep_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;

    // A completed wide handshake frees the output; a closing beat below may refill it.
    if (out_valid_q && axis.dest_tready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (closing) begin
        out_valid_d = 1'b1;
        out_data_d  = merged_data;
        out_keep_d  = merged_keep;
        out_last_d  = axis.src_tlast;
        acc_data_d  = '0;
        acc_keep_d  = '0;
        cnt_d       = '0;
      end else begin
        acc_data_d  = merged_data;
        acc_keep_d  = merged_keep;
        cnt_d       = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset drops any partial group and any pending output word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_data_q  <= acc_data_d;
      acc_keep_q  <= acc_keep_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

  assign axis.src_tready  = src_ready;
  assign axis.dest_tvalid = out_valid_q;
  assign axis.dest_tdata  = out_data_q;
  assign axis.dest_tkeep  = out_keep_q;
  assign axis.dest_tlast  = out_last_q;

endmodule

// File: tb/tb_axistream_pack.sv
// Bench for axistream_pack: a big-endian and a little-endian instance share
// the same narrow stimulus; a group-level reference model predicts every
// cycle's ready/valid and the packed word for both lane orders.
module tb_axistream_pack;

  localparam int DW = 8;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          src_tvalid = 1'b0;
  logic [DW-1:0] src_tdata  = '0;
  logic          src_tlast  = 1'b0;
  logic          dest_tready = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  axistream_pack_if #(.DATA_WIDTH(DW), .NUM_PACK(NP)) ifb ();
  axistream_pack_if #(.DATA_WIDTH(DW), .NUM_PACK(NP)) ifl ();

  assign ifb.src_tvalid  = src_tvalid;
  assign ifb.src_tdata   = src_tdata;
  assign ifb.src_tlast   = src_tlast;
  assign ifb.dest_tready = dest_tready;
  assign ifl.src_tvalid  = src_tvalid;
  assign ifl.src_tdata   = src_tdata;
  assign ifl.src_tlast   = src_tlast;
  assign ifl.dest_tready = dest_tready;

  axistream_pack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .BIG_ENDIAN(1'b1)) u_be (
    .clk (clk),
    .rst (rst),
    .axis(ifb.slave)
  );

  axistream_pack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .BIG_ENDIAN(1'b0)) u_le (
    .clk (clk),
    .rst (rst),
    .axis(ifl.slave)
  );

  always #5 clk = ~clk;

  // Reference model: the beats of the open group, and the word on the output.
  logic [DW-1:0]      grp[$];
  bit                 m_valid = 1'b0;
  logic [NP*DW-1:0]   m_data_b = '0;
  logic [NP*DW-1:0]   m_data_l = '0;
  logic [NP-1:0]      m_keep_b = '0;
  logic [NP-1:0]      m_keep_l = '0;
  bit                 m_last = 1'b0;
  bit                 exp_ready = 1'b1;

  // Apply one cycle's inputs (called just after a rising edge) and let them settle.
  task automatic drive(input bit v, input logic [DW-1:0] d, input bit l, input bit r);
    src_tvalid  = v;
    src_tdata   = d;
    src_tlast   = l;
    dest_tready = r;
    exp_ready   = !m_valid || r;
    #2;
  endtask

  // Update the model with this cycle's transfers, then step to just past the next edge.
  task automatic advance();
    bit acc;
    acc = src_tvalid && exp_ready;
    if (m_valid && dest_tready) m_valid = 1'b0;
    if (acc) begin
      grp.push_back(src_tdata);
      if (grp.size() == NP || src_tlast) begin
        m_data_b = '0; m_keep_b = '0; m_data_l = '0; m_keep_l = '0;
        for (int i = 0; i < grp.size(); i++) begin
          m_data_b = m_data_b | ((NP*DW)'(grp[i]) << (DW * (NP - 1 - i)));
          m_keep_b[NP-1-i] = 1'b1;
          m_data_l = m_data_l | ((NP*DW)'(grp[i]) << (DW * i));
          m_keep_l[i] = 1'b1;
        end
        m_last  = src_tlast;
        m_valid = 1'b1;
        grp.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [77:0] obs();
    return {ifb.src_tready, ifl.src_tready, ifb.dest_tvalid, ifl.dest_tvalid,
            m_valid ? {ifb.dest_tdata, ifb.dest_tkeep, ifb.dest_tlast,
                       ifl.dest_tdata, ifl.dest_tkeep, ifl.dest_tlast} : 74'b0};
  endfunction

  function automatic logic [77:0] expv();
    return {exp_ready, exp_ready, m_valid, m_valid,
            m_valid ? {m_data_b, m_keep_b, m_last, m_data_l, m_keep_l, m_last} : 74'b0};
  endfunction

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    vectors++;
    if ({ifb.dest_tvalid, ifb.dest_tdata, ifb.dest_tkeep, ifb.dest_tlast,
         ifl.dest_tvalid, ifl.dest_tdata, ifl.dest_tkeep, ifl.dest_tlast} !== 76'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got be=%h/%h le=%h/%h want all zero",
               ifb.dest_tdata, ifb.dest_tkeep, ifl.dest_tdata, ifl.dest_tkeep);
    end
    vectors++;
    if ({ifb.src_tready, ifl.src_tready} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 11", {ifb.src_tready, ifl.src_tready});
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] b [4];
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, b[i], i == 3, 1'b1);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL basic_cycle%0d: got %h want %h", i, obs(), expv());
      end
      advance();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if ({ifb.dest_tvalid, ifb.dest_tdata, ifb.dest_tkeep, ifb.dest_tlast} !== {1'b1, 32'h11223344, 4'hF, 1'b1}) begin
      miscompares++;
      $display("FAIL basic_be_word: got %b %h %h %b want 1 11223344 f 1",
               ifb.dest_tvalid, ifb.dest_tdata, ifb.dest_tkeep, ifb.dest_tlast);
    end
    vectors++;
    if ({ifl.dest_tvalid, ifl.dest_tdata, ifl.dest_tkeep, ifl.dest_tlast} !== {1'b1, 32'h44332211, 4'hF, 1'b1}) begin
      miscompares++;
      $display("FAIL basic_le_word: got %b %h %h %b want 1 44332211 f 1",
               ifl.dest_tvalid, ifl.dest_tdata, ifl.dest_tkeep, ifl.dest_tlast);
    end
    advance();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if (obs() !== expv()) begin
      miscompares++;
      $display("FAIL basic_valid_one_cycle: got %h want %h", obs(), expv());
    end
    advance();
  endtask

  task automatic test_short();
    logic [DW-1:0] b [6];
    b = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++;
        if ({ifb.dest_tdata, ifb.dest_tkeep, ifl.dest_tdata, ifl.dest_tkeep} !==
            {32'hAABB0000, 4'hC, 32'h0000BBAA, 4'h3}) begin
          miscompares++;
          $display("FAIL short_word: got be=%h/%h le=%h/%h want AABB0000/c 0000BBAA/3",
                   ifb.dest_tdata, ifb.dest_tkeep, ifl.dest_tdata, ifl.dest_tkeep);
        end
        advance();
      end
      drive(1'b1, b[i], (i == 1) || (i == 5), 1'b1);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL short_cycle%0d: got %h want %h", i, obs(), expv());
      end
      advance();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if ({ifb.dest_tvalid, ifb.dest_tdata, ifb.dest_tkeep} !== {1'b1, 32'h01020304, 4'hF}) begin
      miscompares++;
      $display("FAIL short_next_word: got %b %h %h want 1 01020304 f",
               ifb.dest_tvalid, ifb.dest_tdata, ifb.dest_tkeep);
    end
    advance();
  endtask

  task automatic test_single();
    drive(1'b1, 8'h5A, 1'b1, 1'b1);
    advance();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if ({ifb.dest_tdata, ifb.dest_tkeep, ifl.dest_tdata, ifl.dest_tkeep, ifb.dest_tlast} !==
        {32'h5A000000, 4'h8, 32'h0000005A, 4'h1, 1'b1}) begin
      miscompares++;
      $display("FAIL single_lane: got be=%h/%h le=%h/%h want 5A000000/8 0000005A/1",
               ifb.dest_tdata, ifb.dest_tkeep, ifl.dest_tdata, ifl.dest_tkeep);
    end
    advance();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] b [8];
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, b[i], i == 3, 1'b1);
      advance();
    end
    for (int s = 0; s < 5; s++) begin
      drive(1'b1, 8'h55, 1'b0, 1'b0);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: got %h want %h", s, obs(), expv());
      end
      vectors++;
      if ({ifb.src_tready, ifb.dest_tvalid, ifb.dest_tdata} !== {1'b0, 1'b1, 32'h11223344}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got ready=%b valid=%b data=%h want 0 1 11223344",
                 s, ifb.src_tready, ifb.dest_tvalid, ifb.dest_tdata);
      end
      advance();
    end
    for (int i = 4; i < 8; i++) begin
      drive(1'b1, b[i], i == 7, 1'b1);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL release_cycle%0d: got %h want %h", i, obs(), expv());
      end
      advance();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if ({ifb.dest_tvalid, ifb.dest_tdata, ifl.dest_tdata} !== {1'b1, 32'h55667788, 32'h88776655}) begin
      miscompares++;
      $display("FAIL release_word: got %b %h %h want 1 55667788 88776655",
               ifb.dest_tvalid, ifb.dest_tdata, ifl.dest_tdata);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i + 1), i == 7, 1'b1);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL stream_cycle%0d: got %h want %h", i, obs(), expv());
      end
      if (i == 4) begin
        vectors++;
        if ({ifb.dest_tvalid, ifb.dest_tdata, ifb.dest_tlast} !== {1'b1, 32'h01020304, 1'b0}) begin
          miscompares++;
          $display("FAIL stream_word0: got %b %h %b want 1 01020304 0",
                   ifb.dest_tvalid, ifb.dest_tdata, ifb.dest_tlast);
        end
      end
      advance();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if ({ifb.dest_tvalid, ifb.dest_tdata, ifb.dest_tlast} !== {1'b1, 32'h05060708, 1'b1}) begin
      miscompares++;
      $display("FAIL stream_word1: got %b %h %b want 1 05060708 1",
               ifb.dest_tvalid, ifb.dest_tdata, ifb.dest_tlast);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'hDE, 1'b0, 1'b1);
    advance();
    drive(1'b1, 8'hAD, 1'b0, 1'b1);
    advance();
    src_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if ({ifb.dest_tvalid, ifb.dest_tdata, ifb.dest_tkeep, ifb.dest_tlast,
         ifl.dest_tvalid, ifl.dest_tdata, ifl.dest_tkeep, ifl.dest_tlast} !== 76'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got be=%b/%h le=%b/%h want zero",
               ifb.dest_tvalid, ifb.dest_tdata, ifl.dest_tvalid, ifl.dest_tdata);
    end
    rst = 1'b1;
    grp.delete();
    m_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(i + 1), i == 3, 1'b1);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL midreset_cycle%0d: got %h want %h", i, obs(), expv());
      end
      advance();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if ({ifb.dest_tvalid, ifb.dest_tdata, ifb.dest_tkeep} !== {1'b1, 32'h01020304, 4'hF}) begin
      miscompares++;
      $display("FAIL midreset_word: got %b %h %h want 1 01020304 f",
               ifb.dest_tvalid, ifb.dest_tdata, ifb.dest_tkeep);
    end
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h want %h", n, obs(), expv());
      end
      advance();
    end
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL random_drain%0d: got %h want %h", n, obs(), expv());
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "time limit");
  end

endmodule
